// File: rtl/s_axi_wr_reg.sv
// AXI3 write-only slave exposing a small register file; one burst in flight at a time.
// Optional S_AXI_WR_REG_WRCNT_EN adds wr_count_o, a count of OKAY write responses.
module s_axi_wr_reg #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_QUANTITY = 6,
  parameter logic [63:0] BASE_ADDR    = 64'h0
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [3:0]            awid_i,
  input  logic [3:0]            awlen_i,
  input  logic [2:0]            awsize_i,
  input  logic [1:0]            awburst_i,
  input  logic [63:0]           awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [3:0]            wid_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]            wstrb_i,
  input  logic                  wlast_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [3:0]            bid_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [DATA_WIDTH-1:0] regs_o [0:REG_QUANTITY-1]
`ifdef S_AXI_WR_REG_WRCNT_EN
  ,
  output logic [31:0]           wr_count_o
`endif
);

  localparam int unsigned LANES = (DATA_WIDTH / 8 < 4) ? DATA_WIDTH / 8 : 4;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t      state;
  logic [3:0]  aw_id;
  logic [3:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [63:0] beat_addr;
  logic [3:0]  beat_cnt;
  logic        err_dec;
  logic        err_slv;

  logic [63:0] beat_off;
  logic [63:0] beat_idx;
  logic        burst_bad;
  logic        beat_in_range;
  logic        beat_wr;
  logic        beat_dec;
  logic        beat_slv;
  logic        last_beat;
  logic        w_hs;
  logic        dec_final;
  logic        slv_final;

  logic unused;
  assign unused = ^wid_i;

  always_comb begin
    beat_off      = beat_addr - BASE_ADDR;
    beat_idx      = beat_off >> 2;
    // beat_addr keeps the start address low bits, so misalignment shows on every beat
    burst_bad     = (aw_size != 3'd2) || aw_burst[1] || (beat_addr[1:0] != 2'b00);
    beat_in_range = (beat_addr >= BASE_ADDR) && (beat_idx < 64'(REG_QUANTITY)) &&
                    (beat_addr[1:0] == 2'b00);
    beat_wr       = !burst_bad && beat_in_range;
    beat_dec      = !burst_bad && !beat_in_range;
    last_beat     = (beat_cnt == aw_len);
    beat_slv      = burst_bad || (wlast_i != last_beat);
    w_hs          = (state == DATA) && wvalid_i && wready_o;
    dec_final     = err_dec || beat_dec;
    slv_final     = err_slv || beat_slv;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state     <= IDLE;
      awready_o <= 1'b0;
      wready_o  <= 1'b0;
      bvalid_o  <= 1'b0;
      bid_o     <= '0;
      bresp_o   <= '0;
      aw_id     <= '0;
      aw_len    <= '0;
      aw_size   <= '0;
      aw_burst  <= '0;
      beat_addr <= '0;
      beat_cnt  <= '0;
      err_dec   <= 1'b0;
      err_slv   <= 1'b0;
      for (int unsigned r = 0; r < REG_QUANTITY; r++) regs_o[r] <= '0;
`ifdef S_AXI_WR_REG_WRCNT_EN
      wr_count_o <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (awvalid_i && awready_o) begin
            aw_id     <= awid_i;
            aw_len    <= awlen_i;
            aw_size   <= awsize_i;
            aw_burst  <= awburst_i;
            beat_addr <= awaddr_i;
            beat_cnt  <= '0;
            err_dec   <= 1'b0;
            err_slv   <= 1'b0;
            awready_o <= 1'b0;
            wready_o  <= 1'b1;
            state     <= DATA;
          end else begin
            awready_o <= 1'b1;
          end
        end
        DATA: begin
          if (w_hs) begin
            for (int unsigned r = 0; r < REG_QUANTITY; r++) begin
              if (beat_wr && (beat_idx == 64'(r))) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                  if (wstrb_i[i]) regs_o[r][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
              end
            end
            if (aw_burst == 2'b01) beat_addr <= beat_addr + 64'd4;
            beat_cnt <= beat_cnt + 4'd1;
            err_dec  <= dec_final;
            err_slv  <= slv_final;
            if (last_beat) begin
              wready_o <= 1'b0;
              bvalid_o <= 1'b1;
              bid_o    <= aw_id;
              bresp_o  <= dec_final ? 2'b11 : (slv_final ? 2'b10 : 2'b00);
              state    <= RESP;
            end
          end
        end
        RESP: begin
          if (bready_i) begin
            bvalid_o  <= 1'b0;
            awready_o <= 1'b1;
            state     <= IDLE;
`ifdef S_AXI_WR_REG_WRCNT_EN
            if (bresp_o == 2'b00) wr_count_o <= wr_count_o + 32'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_axi_wr_reg.sv
// Directed bench for s_axi_wr_reg: expected B responses and register snapshots go
// into a scoreboard queue; a monitor compares them at every B handshake.
module tb_s_axi_wr_reg;

  localparam logic [63:0] B = 64'h1000;

  logic        clk;
  logic        areset;
  logic [3:0]  awid_i;
  logic [3:0]  awlen_i;
  logic [2:0]  awsize_i;
  logic [1:0]  awburst_i;
  logic [63:0] awaddr_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [3:0]  wid_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wlast_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [31:0] regs [0:5];
`ifdef S_AXI_WR_REG_WRCNT_EN
  logic [31:0] wr_count_o;
`endif

  s_axi_wr_reg #(.DATA_WIDTH(32), .REG_QUANTITY(6), .BASE_ADDR(B)) dut (
    .clk(clk), .areset(areset),
    .awid_i(awid_i), .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .regs_o(regs)
`ifdef S_AXI_WR_REG_WRCNT_EN
    , .wr_count_o(wr_count_o)
`endif
  );

  typedef struct packed {
    logic [3:0]       id;
    logic [1:0]       resp;
    logic [5:0][31:0] r;
  } exp_t;

  exp_t             sb [$];
  exp_t             mon_e;
  logic [5:0][31:0] mr;
  int               checks = 0;
  int               errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=no_handshake required=handshake", name);
  endtask

  task automatic push_exp(input logic [3:0] id, input logic [1:0] resp);
    sb.push_back(exp_t'{id, resp, mr});
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [63:0] addr);
    int n = 0;
    awid_i = id; awlen_i = len; awsize_i = size; awburst_i = burst; awaddr_i = addr;
    awvalid_i = 1'b1;
    while (!awready_o && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) timeout("aw");
    @(posedge clk); #1;
    awvalid_i = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata_i = data; wstrb_i = strb; wlast_i = last; wvalid_i = 1'b1;
    while (!wready_o && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) timeout("w");
    @(posedge clk); #1;
    wvalid_i = 1'b0;
  endtask

  task automatic do_b(input int hold, input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    bready_i = 1'b0;
    while (!bvalid_o && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) timeout("b");
    for (int k = 0; k < hold; k++) begin
      chk($sformatf("hold_bvalid_%0d", k), bvalid_o, 1'b1);
      chk($sformatf("hold_bresp_%0d", k), bresp_o, resp);
      chk($sformatf("hold_bid_%0d", k), bid_o, id);
      @(posedge clk); #1;
    end
    bready_i = 1'b1;
    @(posedge clk); #1;
    bready_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (areset && bvalid_o && bready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_b actual=bid_%0h required=none", bid_o);
      end else begin
        mon_e = sb.pop_front();
        chk("bid", bid_o, mon_e.id);
        chk("bresp", bresp_o, mon_e.resp);
        for (int i = 0; i < 6; i++) chk($sformatf("regs_%0d", i), regs[i], mon_e.r[i]);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    areset = 1'b0; awid_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awaddr_i = '0;
    awvalid_i = 1'b0; wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0;
    wvalid_i = 1'b0; bready_i = 1'b0; mr = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", awready_o, 1'b0);
    chk("rst_wready", wready_o, 1'b0);
    chk("rst_bvalid", bvalid_o, 1'b0);
    chk("rst_bid", bid_o, 4'h0);
    chk("rst_bresp", bresp_o, 2'b00);
    for (int i = 0; i < 6; i++) chk($sformatf("rst_regs_%0d", i), regs[i], 32'h0);
    areset = 1'b1;
    @(posedge clk); #1;
    chk("awready_after_rst", awready_o, 1'b1);

    // single write
    mr[2] = 32'hDEADBEEF; push_exp(4'h3, 2'b00);
    do_aw(4'h3, 4'd0, 3'd2, 2'b01, B + 64'd8);
    do_w(32'hDEADBEEF, 4'hF, 1'b1);
    do_b(0, 4'h3, 2'b00);

    // INCR burst of four
    mr[0] = 32'd1; mr[1] = 32'd2; mr[2] = 32'd3; mr[3] = 32'd4; push_exp(4'h5, 2'b00);
    do_aw(4'h5, 4'd3, 3'd2, 2'b01, B);
    for (int k = 0; k < 4; k++) do_w(32'(k + 1), 4'hF, k == 3);
    do_b(0, 4'h5, 2'b00);

    // partial strobe onto a cleared register
    mr[1] = 32'h0; push_exp(4'h1, 2'b00);
    do_aw(4'h1, 4'd0, 3'd2, 2'b01, B + 64'd4);
    do_w(32'h0, 4'hF, 1'b1);
    do_b(0, 4'h1, 2'b00);
    mr[1] = 32'h00BB00DD; push_exp(4'h2, 2'b00);
    do_aw(4'h2, 4'd0, 3'd2, 2'b01, B + 64'd4);
    do_w(32'hAABBCCDD, 4'b0101, 1'b1);
    do_b(0, 4'h2, 2'b00);

    // burst running off the end of the file
    mr[4] = 32'd7; mr[5] = 32'd8; push_exp(4'h7, 2'b11);
    do_aw(4'h7, 4'd2, 3'd2, 2'b01, B + 64'd16);
    do_w(32'd7, 4'hF, 1'b0);
    do_w(32'd8, 4'hF, 1'b0);
    do_w(32'd9, 4'hF, 1'b1);
    do_b(0, 4'h7, 2'b11);

    // FIXED burst: last beat wins
    mr[3] = 32'h33; push_exp(4'h9, 2'b00);
    do_aw(4'h9, 4'd2, 3'd2, 2'b00, B + 64'd12);
    do_w(32'h11, 4'hF, 1'b0);
    do_w(32'h22, 4'hF, 1'b0);
    do_w(32'h33, 4'hF, 1'b1);
    do_b(0, 4'h9, 2'b00);

    // early wlast: burst length unchanged, SLVERR
    mr[0] = 32'hA0; mr[1] = 32'hA1; push_exp(4'h4, 2'b10);
    do_aw(4'h4, 4'd1, 3'd2, 2'b01, B);
    do_w(32'hA0, 4'hF, 1'b1);
    do_w(32'hA1, 4'hF, 1'b0);
    do_b(0, 4'h4, 2'b10);

    // W beats while idle are not accepted
    wdata_i = 32'hCAFEBABE; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle_wready_%0d", k), wready_o, 1'b0);
      @(posedge clk); #1;
    end
    wvalid_i = 1'b0;

    // illegal size with backpressure
    push_exp(4'h6, 2'b10);
    do_aw(4'h6, 4'd0, 3'd1, 2'b01, B);
    do_w(32'hFFFFFFFF, 4'hF, 1'b1);
    do_b(5, 4'h6, 2'b10);
    chk("awready_after_b", awready_o, 1'b1);

    // reset in the middle of a burst
    do_aw(4'hA, 4'd3, 3'd2, 2'b01, B);
    do_w(32'h55, 4'hF, 1'b0);
    do_w(32'h66, 4'hF, 1'b0);
    areset = 1'b0;
    #2;
    mr = '0;
    for (int i = 0; i < 6; i++) chk($sformatf("midrst_regs_%0d", i), regs[i], 32'h0);
    chk("midrst_bvalid", bvalid_o, 1'b0);
    chk("midrst_awready", awready_o, 1'b0);
    chk("midrst_wready", wready_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b1;
    @(posedge clk); #1;
    chk("awready_after_midrst", awready_o, 1'b1);
    mr[5] = 32'h12345678; push_exp(4'h8, 2'b00);
    do_aw(4'h8, 4'd0, 3'd2, 2'b01, B + 64'd20);
    do_w(32'h12345678, 4'hF, 1'b1);
    do_b(0, 4'h8, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
`ifdef S_AXI_WR_REG_WRCNT_EN
    chk("wr_count", wr_count_o, 32'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
